// File: rtl/car_park_occupancy.sv
// Multi-gate car park occupancy counter: per-gate sensor FSMs feed one saturating counter.
// Optional CAR_PARK_BCD_EN adds a registered 3-digit BCD mirror of the count.
module car_park_occupancy #(
  parameter int N_GATES = 2,
  parameter int CAP     = 99,
  parameter int W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_GATES-1:0] a,
  input  logic [N_GATES-1:0] b,
  output logic [N_GATES-1:0] enter_tick,
  output logic [N_GATES-1:0] exit_tick,
  output logic [W-1:0]       count,
  output logic               full,
  output logic               empty,
  output logic               reject,
  output logic [11:0]        count_bcd
);

  localparam int SW = W + 6;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ABORT} state_t;

  function automatic logic [3:0] popcnt(input logic [N_GATES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_GATES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [W-1:0] sat_count(input logic signed [SW-1:0] s);
    if (s[SW-1])     return '0;
    else if (s > CAP_S) return W'(CAP);
    else             return s[W-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [SW-1:0] s);
    return s[SW-1] || (s > CAP_S);
  endfunction

  // Per-gate passage FSM; each state remembers the sensor pattern it was entered on
  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    state_t     st_q;
    logic       ent_q;
    logic       ext_q;
    logic [1:0] ab;

    assign ab = {a[g], b[g]};

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        ent_q <= 1'b0;
        ext_q <= 1'b0;
      end else begin
        ent_q <= 1'b0;
        ext_q <= 1'b0;
        case (st_q)
          IDLE: case (ab)
            2'b10:   st_q <= EN1;
            2'b01:   st_q <= EX1;
            2'b11:   st_q <= ABORT;
            default: st_q <= IDLE;
          endcase
          EN1: case (ab)
            2'b10:   st_q <= EN1;
            2'b11:   st_q <= EN2;
            2'b00:   st_q <= IDLE;
            default: st_q <= ABORT;
          endcase
          EN2: case (ab)
            2'b11:   st_q <= EN2;
            2'b01:   st_q <= EN3;
            2'b10:   st_q <= EN1;
            default: st_q <= ABORT;
          endcase
          EN3: case (ab)
            2'b01:   st_q <= EN3;
            2'b11:   st_q <= EN2;
            2'b00: begin
              st_q  <= IDLE;
              ent_q <= 1'b1;
            end
            default: st_q <= ABORT;
          endcase
          EX1: case (ab)
            2'b01:   st_q <= EX1;
            2'b11:   st_q <= EX2;
            2'b00:   st_q <= IDLE;
            default: st_q <= ABORT;
          endcase
          EX2: case (ab)
            2'b11:   st_q <= EX2;
            2'b10:   st_q <= EX3;
            2'b01:   st_q <= EX1;
            default: st_q <= ABORT;
          endcase
          EX3: case (ab)
            2'b10:   st_q <= EX3;
            2'b11:   st_q <= EX2;
            2'b00: begin
              st_q  <= IDLE;
              ext_q <= 1'b1;
            end
            default: st_q <= ABORT;
          endcase
          default: if (ab == 2'b00) st_q <= IDLE;
        endcase
      end
    end

    assign enter_tick[g] = ent_q;
    assign exit_tick[g]  = ext_q;
  end

  // Occupancy update: all gates net together before clamping
  logic [W-1:0]          count_q, count_d;
  logic                  full_q, empty_q, reject_q;
  logic signed [4:0]     net;
  logic signed [SW-1:0]  sum;

  always_comb begin
    net     = $signed({1'b0, popcnt(enter_tick)}) - $signed({1'b0, popcnt(exit_tick)});
    sum     = $signed({{(SW-W){1'b0}}, count_q}) + $signed({{(SW-5){net[4]}}, net});
    count_d = sat_count(sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= (count_d == W'(CAP));
      empty_q  <= (count_d == '0);
      reject_q <= sat_hit(sum);
    end
  end

  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign reject = reject_q;

`ifdef CAR_PARK_BCD_EN
  function automatic logic [11:0] bcd_add(input logic [11:0] v, input logic [3:0] m);
    logic [11:0] r;
    logic [4:0]  d;
    logic [4:0]  c;
    r = '0;
    c = {1'b0, m};
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, v[4*i +: 4]} + c;
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 5'd1;
      end else begin
        c = 5'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_sub(input logic [11:0] v, input logic [3:0] m);
    logic [11:0] r;
    logic [4:0]  d;
    logic [4:0]  c;
    r = '0;
    c = {1'b0, m};
    for (int i = 0; i < 3; i++) begin
      if ({1'b0, v[4*i +: 4]} < c) begin
        d = {1'b0, v[4*i +: 4]} + 5'd10 - c;
        c = 5'd1;
      end else begin
        d = {1'b0, v[4*i +: 4]} - c;
        c = 5'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  // BCD tracks the already-clamped binary step, so both saturate identically
  logic [11:0]          bcd_q, bcd_d;
  logic signed [SW-1:0] delta, mag;

  always_comb begin
    delta = $signed({{(SW-W){1'b0}}, count_d}) - $signed({{(SW-W){1'b0}}, count_q});
    mag   = delta[SW-1] ? -delta : delta;
    bcd_d = delta[SW-1] ? bcd_sub(bcd_q, mag[3:0]) : bcd_add(bcd_q, mag[3:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign count_bcd = bcd_q;
`else
  assign count_bcd = 12'h000;
`endif

endmodule

// File: tb/tb_car_park_occupancy.sv
// Randomised and directed bench for car_park_occupancy against a path-index reference model.
module tb_car_park_occupancy;
  localparam int N   = 2;
  localparam int CAP = 99;
  localparam int W   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  a, b;
  logic [N-1:0]  enter_tick, exit_tick;
  logic [W-1:0]  count;
  logic          full, empty, reject;
  logic [11:0]   count_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each gate is a direction (0 none, 1 entry, 2 exit) plus progress index
  int m_cnt;
  bit m_full, m_empty, m_rej;
  bit [N-1:0] m_en, m_ex;
  int m_dir[N];
  int m_idx[N];
  bit m_abort[N];

  car_park_occupancy #(.N_GATES(N), .CAP(CAP), .W(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter_tick(enter_tick), .exit_tick(exit_tick),
    .count(count), .full(full), .empty(empty), .reject(reject),
    .count_bcd(count_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sensor pattern {a,b} at step k of a passage in the given direction
  function automatic int pat(input int dir, input int k);
    case (k)
      0:       return 0;
      1:       return (dir == 1) ? 2 : 1;
      2:       return 3;
      default: return (dir == 1) ? 1 : 2;
    endcase
  endfunction

  function automatic int to_bcd(input int c);
    return ((c / 100) << 8) | (((c / 10) % 10) << 4) | (c % 10);
  endfunction

  task automatic model_update();
    int sum;
    if (reset) begin
      m_cnt = 0; m_full = 0; m_empty = 1; m_rej = 0; m_en = '0; m_ex = '0;
      for (int g = 0; g < N; g++) begin
        m_dir[g] = 0; m_idx[g] = 0; m_abort[g] = 0;
      end
      return;
    end
    sum = m_cnt + $countones(m_en) - $countones(m_ex);
    m_rej = (sum < 0) || (sum > CAP);
    m_cnt = (sum < 0) ? 0 : (sum > CAP) ? CAP : sum;
    m_full = (m_cnt == CAP);
    m_empty = (m_cnt == 0);
    for (int g = 0; g < N; g++) begin
      int x;
      x = {30'd0, a[g], b[g]};
      m_en[g] = 0;
      m_ex[g] = 0;
      if (m_abort[g]) begin
        if (x == 0) m_abort[g] = 0;
      end else if (m_dir[g] == 0) begin
        if (x == 2)      begin m_dir[g] = 1; m_idx[g] = 1; end
        else if (x == 1) begin m_dir[g] = 2; m_idx[g] = 1; end
        else if (x == 3) m_abort[g] = 1;
      end else if (x == pat(m_dir[g], m_idx[g])) begin
        // stays put
      end else if (m_idx[g] < 3 && x == pat(m_dir[g], m_idx[g] + 1)) begin
        m_idx[g]++;
      end else if (m_idx[g] == 3 && x == 0) begin
        if (m_dir[g] == 1) m_en[g] = 1; else m_ex[g] = 1;
        m_dir[g] = 0; m_idx[g] = 0;
      end else if (x == pat(m_dir[g], m_idx[g] - 1)) begin
        m_idx[g]--;
        if (m_idx[g] == 0) m_dir[g] = 0;
      end else begin
        m_abort[g] = 1; m_dir[g] = 0; m_idx[g] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("count", int'(count), m_cnt);
    check("full", int'(full), int'(m_full));
    check("empty", int'(empty), int'(m_empty));
    check("reject", int'(reject), int'(m_rej));
    check("enter_tick", int'(enter_tick), int'(m_en));
    check("exit_tick", int'(exit_tick), int'(m_ex));
`ifdef CAR_PARK_BCD_EN
    check("count_bcd", int'(count_bcd), to_bcd(m_cnt));
`else
    check("count_bcd", int'(count_bcd), 0);
`endif
  endtask

  task automatic drive(input logic [1:0] p0, input logic [1:0] p1);
    a = {p1[1], p0[1]};
    b = {p1[0], p0[0]};
    step();
  endtask

  function automatic logic [1:0] pick(input int g);
    int r, x;
    r = $urandom_range(0, 19);
    if (r == 19)                x = $urandom_range(0, 3);
    else if (m_abort[g])        x = 0;
    else if (m_dir[g] == 0)     x = (r < 8) ? 0 : (r < 13) ? 2 : (r < 18) ? 1 : 3;
    else if (r < 10)            x = (m_idx[g] < 3) ? pat(m_dir[g], m_idx[g] + 1) : 0;
    else if (r < 16)            x = pat(m_dir[g], m_idx[g]);
    else                        x = pat(m_dir[g], m_idx[g] - 1);
    return 2'(x);
  endfunction

  initial begin
    reset = 1'b1;
    a = '0;
    b = '0;
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_bcd", int'(count_bcd), 0);
    reset = 1'b0;
    drive(2'b00, 2'b00);

    // Single entry on gate 0
    drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b00, 2'b00);
    check("entry_tick", int'(enter_tick), 1);
    drive(2'b00, 2'b00);
    check("entry_count", int'(count), 1);
    check("entry_empty", int'(empty), 0);

    // Single exit on gate 1
    drive(2'b00, 2'b01); drive(2'b00, 2'b11); drive(2'b00, 2'b10); drive(2'b00, 2'b00);
    check("exit_tick", int'(exit_tick), 2);
    drive(2'b00, 2'b00);
    check("exit_count", int'(count), 0);
    check("exit_empty", int'(empty), 1);
    check("exit_reject", int'(reject), 0);

    // Reversal, then abort from IDLE
    drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b10, 2'b00); drive(2'b00, 2'b00);
    drive(2'b11, 2'b00); drive(2'b00, 2'b00); drive(2'b00, 2'b00);
    check("reverse_count", int'(count), 0);

    // Exit and entry at count 0 cancel
    drive(2'b01, 2'b10); drive(2'b11, 2'b11); drive(2'b10, 2'b01); drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("mix0_count", int'(count), 0);
    check("mix0_reject", int'(reject), 0);

    // Fill to 98 with paired entries
    for (int i = 0; i < 49; i++) begin
      drive(2'b10, 2'b10); drive(2'b11, 2'b11); drive(2'b01, 2'b01); drive(2'b00, 2'b00);
    end
    drive(2'b00, 2'b00);
    check("fill_count", int'(count), 98);
    drive(2'b10, 2'b10); drive(2'b11, 2'b11); drive(2'b01, 2'b01); drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("cap_count", int'(count), 99);
    check("cap_full", int'(full), 1);
    check("cap_reject", int'(reject), 1);
    drive(2'b00, 2'b00);
    check("cap_reject_pulse", int'(reject), 0);
    drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("over_count", int'(count), 99);
    check("over_reject", int'(reject), 1);

    // Entry plus exit at CAP nets to zero
    drive(2'b10, 2'b01); drive(2'b11, 2'b11); drive(2'b01, 2'b10); drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("mixcap_count", int'(count), 99);
    check("mixcap_reject", int'(reject), 0);

    // Reset mid-passage with sensors still blocked
    drive(2'b10, 2'b00); drive(2'b11, 2'b00);
    reset = 1'b1;
    drive(2'b11, 2'b00);
    check("midrst_count", int'(count), 0);
    reset = 1'b0;
    drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b00, 2'b00); drive(2'b00, 2'b00);
    check("midrst_notick", int'(count), 0);
    drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    check("midrst_fresh", int'(count), 1);

    // Random traffic on both gates with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] p0, p1;
      p0 = pick(0);
      p1 = pick(1);
      reset = ($urandom_range(0, 299) == 0);
      drive(p0, p1);
    end
    reset = 1'b0;
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
